// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite ROM and streams clipped pixel writes to a vga_adapter.
// Optional build macro SPRITE_TRANSPARENT_EN: ROM bit 1 pixels are not plotted (transparent background).
module sprite_blitter #(
  parameter int SPR_W    = 80,
  parameter int SPR_H    = 120,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 120,
  parameter int ADDR_W   = 15,
  parameter int COLOUR_W = 3,
  parameter int N_SPR    = 3,
  parameter int SEL_W    = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                start,
  input  logic [7:0]          x0,
  input  logic [6:0]          y0,
  input  logic [SEL_W-1:0]    sel,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic [COLOUR_W-1:0] bg_colour,
  input  logic [N_SPR-1:0]    rom_q,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW   = 3'd1,
    S_FLUSH1 = 3'd2,
    S_FLUSH2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [7:0]          r_x0;
  logic [6:0]          r_y0;
  logic [SEL_W-1:0]    r_sel;
  logic [COLOUR_W-1:0] r_fg, r_bg;

  logic                r_s1_valid, r_s1_in;
  logic [7:0]          r_s1_x;
  logic [6:0]          r_s1_y;

  logic                w_accept, w_col_last, w_last, w_rom_bit, w_plot_px;
  logic [8:0]          w_x_wide;
  logic [7:0]          w_y_wide;
  logic [SEL_W-1:0]    w_sel_clamped;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_col_last    = (r_col == CW'(SPR_W - 1));
  assign w_last        = w_col_last && (r_row == RW'(SPR_H - 1));
  assign w_sel_clamped = (32'(sel) >= N_SPR) ? SEL_W'(N_SPR - 1) : sel;

  assign rom_addr  = ADDR_W'(32'(r_row) * 32'(SPR_W) + 32'(r_col));
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  // One bit wider than the port so an origin near the edge cannot wrap back on screen.
  assign w_x_wide = {1'b0, r_x0} + 9'(r_col);
  assign w_y_wide = {1'b0, r_y0} + 8'(r_row);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_DRAW;
      S_DRAW:   if (w_last) w_next = S_FLUSH1;
      S_FLUSH1: w_next = S_FLUSH2;
      S_FLUSH2: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
      r_x0  <= '0;
      r_y0  <= '0;
      r_sel <= '0;
      r_fg  <= '0;
      r_bg  <= '0;
    end else if (w_accept) begin
      r_col <= '0;
      r_row <= '0;
      r_x0  <= x0;
      r_y0  <= y0;
      r_sel <= w_sel_clamped;
      r_fg  <= fg_colour;
      r_bg  <= bg_colour;
    end else if (r_state == S_DRAW) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Stage 1 lines up the pixel position with the ROM's one-cycle read latency.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_in    <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_valid <= (r_state == S_DRAW);
      r_s1_in    <= (32'(w_x_wide) < SCR_W) && (32'(w_y_wide) < SCR_H);
      r_s1_x     <= w_x_wide[7:0];
      r_s1_y     <= w_y_wide[6:0];
    end
  end

  always_comb begin
    w_rom_bit = 1'b0;
    for (int i = 0; i < N_SPR; i++) begin
      if (r_sel == SEL_W'(i)) w_rom_bit = rom_q[i];
    end
  end

`ifdef SPRITE_TRANSPARENT_EN
  assign w_plot_px = r_s1_valid && r_s1_in && !w_rom_bit;
`else
  assign w_plot_px = r_s1_valid && r_s1_in;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      x      <= r_s1_x;
      y      <= r_s1_y;
      colour <= w_rom_bit ? r_bg : r_fg;
      plot   <= w_plot_px;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter (4x2 sprite, 3 ROM channels); reference model walks the sprite
// pixel by pixel and predicts each plotted pixel with the cycle it must appear on.
module tb_sprite_blitter;

  localparam int SPR_W = 4;
  localparam int SPR_H = 2;
  localparam int NPIX  = SPR_W * SPR_H;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [1:0]  sel;
  logic [2:0]  fg_colour, bg_colour;
  logic [2:0]  rom_q;
  logic [14:0] rom_addr;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;
  logic [2:0]  dbg_state;

  sprite_blitter #(.SPR_W(SPR_W), .SPR_H(SPR_H)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .x0(x0), .y0(y0), .sel(sel),
    .fg_colour(fg_colour), .bg_colour(bg_colour), .rom_q(rom_q), .rom_addr(rom_addr),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter / ROM model ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  logic rom_mem [0:2][0:7];
  always @(posedge CLOCK_50) begin
    for (int i = 0; i < 3; i++) rom_q[i] <= rom_mem[i][int'(rom_addr) % 8];
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];   // {cycle[15:0], x[7:0], y[6:0], colour[2:0]}
  int          done_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_plot", {16'(cyc), x, y, colour}, 64'h0);
      end else begin
        chk("pixel", {16'(cyc), x, y, colour}, exp_q.pop_front());
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      if (done_q.size() == 0) chk("unexpected_done", 64'(cyc), 64'h0);
      else                    chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  // s = cycle count right after the start-accepting edge; pixels visible later than cut are dropped.
  task automatic model_draw(input int s, input int cut, input logic [7:0] x0v, input logic [6:0] y0v,
                            input logic [1:0] selv, input logic [2:0] fgv, input logic [2:0] bgv);
    int ch;
    ch = (selv >= 2'd3) ? 2 : int'(selv);
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        int  idx, px, py, t;
        logic b, vis;
        idx = r * SPR_W + c;
        px  = int'(x0v) + c;
        py  = int'(y0v) + r;
        t   = s + 2 + idx;
        b   = rom_mem[ch][idx];
        vis = (px < 160) && (py < 120) && (t <= cut);
`ifdef SPRITE_TRANSPARENT_EN
        vis = vis && (b == 1'b0);
`endif
        if (vis) exp_q.push_back({16'(t), 8'(px), 7'(py), b ? bgv : fgv});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [7:0] xv, input logic [6:0] yv, input logic [1:0] sv,
                            input logic [2:0] fv, input logic [2:0] bv);
    x0 = xv; y0 = yv; sel = sv; fg_colour = fv; bg_colour = bv;
  endtask

  task automatic run_draw(input logic [7:0] xv, input logic [6:0] yv, input logic [1:0] sv,
                          input logic [2:0] fv, input logic [2:0] bv, input bit disturb);
    int s, d0;
    @(negedge CLOCK_50);
    set_inputs(xv, yv, sv, fv, bv);
    start = 1'b1;
    s  = cyc + 1;
    d0 = done_seen;
    model_draw(s, 1 << 30, xv, yv, sv, fv, bv);
    done_q.push_back(s + NPIX + 2);
    do begin
      @(negedge CLOCK_50);
      if (cyc == s) chk("busy_in_draw", 64'(busy), 64'h1);
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        set_inputs(8'($urandom), 7'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));
      end else begin
        start = 1'b0;
      end
    end while (cyc < s + NPIX + 2);
    @(negedge CLOCK_50);
    start = 1'b0;
    chk("busy_after_done", 64'(busy), 64'h0);
    chk("done_pulses", 64'(done_seen - d0), 64'h1);
  endtask

  task automatic run_hold(input logic [7:0] xv, input logic [6:0] yv, input logic [1:0] sv,
                          input logic [2:0] fv, input logic [2:0] bv);
    int s1, s2, d0;
    @(negedge CLOCK_50);
    set_inputs(xv, yv, sv, fv, bv);
    start = 1'b1;
    s1 = cyc + 1;
    s2 = s1 + NPIX + 4;
    d0 = done_seen;
    model_draw(s1, 1 << 30, xv, yv, sv, fv, bv);
    model_draw(s2, 1 << 30, xv, yv, sv, fv, bv);
    done_q.push_back(s1 + NPIX + 2);
    done_q.push_back(s2 + NPIX + 2);
    while (cyc < s2 + 1) @(negedge CLOCK_50);
    start = 1'b0;
    while (cyc < s2 + NPIX + 3) @(negedge CLOCK_50);
    chk("hold_busy_end", 64'(busy), 64'h0);
    chk("hold_done_pulses", 64'(done_seen - d0), 64'h2);
  endtask

  task automatic run_reset_abort();
    int s, d0;
    @(negedge CLOCK_50);
    set_inputs(8'd10, 7'd20, 2'd2, 3'b010, 3'b111);
    start = 1'b1;
    s  = cyc + 1;
    d0 = done_seen;
    model_draw(s, s + 3, 8'd10, 7'd20, 2'd2, 3'b010, 3'b111);
    @(negedge CLOCK_50);
    start = 1'b0;
    while (cyc < s + 3) @(negedge CLOCK_50);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_plot", 64'(plot), 64'h0);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    chk("abort_addr", 64'(rom_addr), 64'h0);
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    chk("abort_idle", 64'(busy), 64'h0);
    chk("abort_no_done", 64'(done_seen - d0), 64'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pat2;
    pat2 = 8'b0011_1010;  // idx0..7 = 0,1,0,1,1,1,0,0
    for (int i = 0; i < 8; i++) begin
      rom_mem[0][i] = 1'($urandom);
      rom_mem[1][i] = 1'($urandom);
      rom_mem[2][i] = pat2[i];
    end
    reset_n = 1'b0;
    start   = 1'b0;
    set_inputs(8'd0, 7'd0, 2'd0, 3'd0, 3'd0);
    repeat (3) @(negedge CLOCK_50);
    chk("rst_plot", 64'(plot), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_xyc", {x, y, colour}, 64'h0);
    chk("rst_addr", 64'(rom_addr), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    run_draw(8'd10,  7'd20,  2'd2, 3'b010, 3'b111, 1'b0);  // reference pattern
    run_draw(8'd158, 7'd119, 2'd2, 3'b010, 3'b111, 1'b0);  // clipping corner
    run_draw(8'd10,  7'd20,  2'd2, 3'b010, 3'b111, 1'b1);  // disturbed while busy
    run_draw(8'd40,  7'd5,   2'd3, 3'b001, 3'b110, 1'b0);  // sel clamp to channel 2
    run_draw(8'd255, 7'd127, 2'd0, 3'b101, 3'b011, 1'b0);  // fully off screen
    run_hold(8'd70,  7'd60,  2'd1, 3'b100, 3'b001);
    run_reset_abort();

    for (int n = 0; n < 12; n++) begin
      logic [7:0] xr;
      xr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(154, 162)) : 8'($urandom);
      run_draw(xr, 7'($urandom_range(0, 127)), 2'($urandom), 3'($urandom), 3'($urandom),
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
    end

    repeat (4) @(negedge CLOCK_50);
    chk("pixels_left", 64'(exp_q.size()), 64'h0);
    chk("dones_left", 64'(done_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
